hdmi_pattern_gen: RTL and testbench

- Parametrised video timing and test-pattern generator in the pixel clock domain.
- Produces hsync, vsync and data-enable plus per-channel colour with runtime-selectable patterns.
- Feeds red/green/blue/sync directly into the HDMI transceiver.
- Replaces constant-colour tie-offs in board bring-up tops; timing is parametrised for any CEA/VESA mode.

---
 rtl/hdmi_pattern_gen.sv | 220 ++++++++++++++++++++++
 tb/tb_hdmi_pattern_gen.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_pattern_gen.sv
// Video timing and test-pattern generator for HDMI bring-up.
// Stage p0 is the h/v counter state. Stage p1 is the registered pin state,
// one cycle behind the counters. Patterns: solid, colour bars, gradient,
// checkerboard and scrolling gradient.
module hdmi_pattern_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int HS_POL   = 0,
   parameter int VS_POL   = 0,
   parameter int CW       = 8,
   parameter int CHK_LOG2 = 5
) (
   input  logic          clk_low,
   input  logic          reset_n,
   input  logic          enable,
   input  logic [2:0]    mode,
   input  logic [CW-1:0] solid_r,
   input  logic [CW-1:0] solid_g,
   input  logic [CW-1:0] solid_b,
   output logic          hsync,
   output logic          vsync,
   output logic          de,
   output logic [CW-1:0] red,
   output logic [CW-1:0] green,
   output logic [CW-1:0] blue,
   output logic [15:0]   pix_x,
   output logic [15:0]   pix_y,
   output logic          frame_start,
   output logic [15:0]   frame_cnt
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [15:0] H_ACT   = 16'(H_ACTIVE);
   localparam logic [15:0] H_SS    = 16'(H_ACTIVE + H_FP);
   localparam logic [15:0] H_SE    = 16'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [15:0] H_LAST  = 16'(H_TOTAL - 1);
   localparam logic [15:0] V_ACT   = 16'(V_ACTIVE);
   localparam logic [15:0] V_SS    = 16'(V_ACTIVE + V_FP);
   localparam logic [15:0] V_SE    = 16'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [15:0] V_LAST  = 16'(V_TOTAL - 1);
   // Colour bar width; H_ACTIVE must be at least 8.
   localparam logic [15:0] BW_LAST = 16'(H_ACTIVE / 8 - 1);

   localparam logic HS_ACT = (HS_POL != 0);
   localparam logic VS_ACT = (VS_POL != 0);

   // Bar colours left to right: white, yellow, cyan, green, magenta, red, blue, black.
   function automatic logic [3*CW-1:0] bar_colour(input logic [2:0] idx);
      logic [2:0] c;
      case (idx)
         3'd0:    c = 3'b111;
         3'd1:    c = 3'b110;
         3'd2:    c = 3'b011;
         3'd3:    c = 3'b010;
         3'd4:    c = 3'b101;
         3'd5:    c = 3'b100;
         3'd6:    c = 3'b001;
         default: c = 3'b000;
      endcase
      return {{CW{c[2]}}, {CW{c[1]}}, {CW{c[0]}}};
   endfunction

   // Same value on all three channels; the slice is the mod 2^CW wrap.
   function automatic logic [3*CW-1:0] grey(input logic [CW-1:0] v);
      return {3{v}};
   endfunction

   function automatic logic [3*CW-1:0] pattern(
      input logic [2:0]    m,
      input logic [15:0]   x,
      input logic          chk_y,
      input logic [2:0]    bar,
      input logic [15:0]   fc,
      input logic [CW-1:0] sr,
      input logic [CW-1:0] sg,
      input logic [CW-1:0] sb
   );
      logic [15:0] sum;
      sum = x + fc;
      case (m)
         3'd0:    return {sr, sg, sb};
         3'd1:    return bar_colour(bar);
         3'd2:    return grey(x[CW-1:0]);
         3'd3:    return (x[CHK_LOG2] ^ chk_y) ? '0 : '1;
         3'd4:    return grey(sum[CW-1:0]);
         default: return '0;
      endcase
   endfunction

   logic [15:0]   h_cnt_p0, v_cnt_p0, bar_cnt_p0;
   logic [2:0]    bar_idx_p0;
   logic [2:0]    mode_p0;
   logic [CW-1:0] solid_r_p0, solid_g_p0, solid_b_p0;
   logic          h_last_p0, frame_end_p0, vld_p0, hs_p0, vs_p0;
   logic [15:0]   x_p0, y_p0;
   logic [3*CW-1:0] rgb_p0;

   logic          hs_p1, vs_p1, vld_p1, fs_p1;
   logic [15:0]   x_p1, y_p1, fc_p1;
   logic [3*CW-1:0] rgb_p1;

   // Advance the line/frame counters and the bar tracker that follows h_cnt.
   always_ff @(posedge clk_low or negedge reset_n) begin
      if (!reset_n) begin
         h_cnt_p0   <= '0;
         v_cnt_p0   <= '0;
         bar_cnt_p0 <= '0;
         bar_idx_p0 <= '0;
      end else if (!enable) begin
         h_cnt_p0   <= '0;
         v_cnt_p0   <= '0;
         bar_cnt_p0 <= '0;
         bar_idx_p0 <= '0;
      end else begin
         if (h_last_p0) begin
            h_cnt_p0 <= '0;
            v_cnt_p0 <= (v_cnt_p0 == V_LAST) ? '0 : v_cnt_p0 + 16'd1;
         end else begin
            h_cnt_p0 <= h_cnt_p0 + 16'd1;
         end
         if (h_last_p0) begin
            bar_cnt_p0 <= '0;
            bar_idx_p0 <= '0;
         end else if (h_cnt_p0 < H_ACT) begin
            if (bar_cnt_p0 == BW_LAST) begin
               bar_cnt_p0 <= '0;
               if (bar_idx_p0 != 3'd7) bar_idx_p0 <= bar_idx_p0 + 3'd1;
            end else begin
               bar_cnt_p0 <= bar_cnt_p0 + 16'd1;
            end
         end
      end
   end

   // Latch mode and solid colour only between frames so a frame never mixes patterns.
   always_ff @(posedge clk_low or negedge reset_n) begin
      if (!reset_n) begin
         mode_p0    <= '0;
         solid_r_p0 <= '0;
         solid_g_p0 <= '0;
         solid_b_p0 <= '0;
      end else if (!enable || frame_end_p0) begin
         mode_p0    <= mode;
         solid_r_p0 <= solid_r;
         solid_g_p0 <= solid_g;
         solid_b_p0 <= solid_b;
      end
   end

   // Decode regions and compute the pixel colour for the current counter state.
   always_comb begin
      h_last_p0    = (h_cnt_p0 == H_LAST);
      frame_end_p0 = h_last_p0 && (v_cnt_p0 == V_LAST);
      vld_p0       = (h_cnt_p0 < H_ACT) && (v_cnt_p0 < V_ACT);
      hs_p0        = (h_cnt_p0 >= H_SS) && (h_cnt_p0 < H_SE);
      vs_p0        = (v_cnt_p0 >= V_SS) && (v_cnt_p0 < V_SE);
      x_p0         = vld_p0 ? h_cnt_p0 : '0;
      y_p0         = vld_p0 ? v_cnt_p0 : '0;
      rgb_p0       = '0;
      if (vld_p0)
         rgb_p0 = pattern(mode_p0, x_p0, y_p0[CHK_LOG2], bar_idx_p0, fc_p1,
                          solid_r_p0, solid_g_p0, solid_b_p0);
   end

   // ---- stage p0 -> p1: register everything that reaches the pins ----
   // Pin registers: idle values while reset or disabled, else the decoded pixel.
   always_ff @(posedge clk_low or negedge reset_n) begin
      if (!reset_n) begin
         hs_p1  <= ~HS_ACT;
         vs_p1  <= ~VS_ACT;
         vld_p1 <= 1'b0;
         fs_p1  <= 1'b0;
         x_p1   <= '0;
         y_p1   <= '0;
         rgb_p1 <= '0;
      end else if (!enable) begin
         hs_p1  <= ~HS_ACT;
         vs_p1  <= ~VS_ACT;
         vld_p1 <= 1'b0;
         fs_p1  <= 1'b0;
         x_p1   <= '0;
         y_p1   <= '0;
         rgb_p1 <= '0;
      end else begin
         hs_p1  <= hs_p0 ? HS_ACT : ~HS_ACT;
         vs_p1  <= vs_p0 ? VS_ACT : ~VS_ACT;
         vld_p1 <= vld_p0;
         fs_p1  <= (h_cnt_p0 == '0) && (v_cnt_p0 == '0);
         x_p1   <= x_p0;
         y_p1   <= y_p0;
         rgb_p1 <= rgb_p0;
      end
   end

   // Completed-frame count; holds while disabled and wraps naturally at 16 bits.
   always_ff @(posedge clk_low or negedge reset_n) begin
      if (!reset_n)                    fc_p1 <= '0;
      else if (enable && frame_end_p0) fc_p1 <= fc_p1 + 16'd1;
   end

   assign hsync       = hs_p1;
   assign vsync       = vs_p1;
   assign de          = vld_p1;
   assign frame_start = fs_p1;
   assign pix_x       = x_p1;
   assign pix_y       = y_p1;
   assign frame_cnt   = fc_p1;
   assign red         = rgb_p1[3*CW-1:2*CW];
   assign green       = rgb_p1[2*CW-1:CW];
   assign blue        = rgb_p1[CW-1:0];

endmodule

// File: tb/tb_hdmi_pattern_gen.sv
// Scoreboard bench for hdmi_pattern_gen on a tiny 24x7 timing.
// Stimulus queues one expected output record per generator cycle.
// A monitor pops and compares on every cycle the generator runs,
// and checks idle values otherwise.
module tb_hdmi_pattern_gen;

   logic        clk_low;
   logic        reset_n;
   logic        enable;
   logic [2:0]  mode;
   logic [7:0]  solid_r, solid_g, solid_b;
   logic        hsync, vsync, de, frame_start;
   logic [7:0]  red, green, blue;
   logic [15:0] pix_x, pix_y, frame_cnt;

   hdmi_pattern_gen #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(4),  .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(0), .VS_POL(0), .CW(8), .CHK_LOG2(1)
   ) dut (
      .clk_low(clk_low), .reset_n(reset_n), .enable(enable), .mode(mode),
      .solid_r(solid_r), .solid_g(solid_g), .solid_b(solid_b),
      .hsync(hsync), .vsync(vsync), .de(de),
      .red(red), .green(green), .blue(blue),
      .pix_x(pix_x), .pix_y(pix_y),
      .frame_start(frame_start), .frame_cnt(frame_cnt)
   );

   typedef struct packed {
      logic        hs, vs, de, fs;
      logic [15:0] x, y, fc;
      logic [7:0]  r, g, b;
   } out_t;

   out_t q[$];
   out_t q_async[$];
   event async_ev;
   int   checks = 0;
   int   errors = 0;
   int   fc_base = 0;
   int   idle_fc = 0;
   logic run_d = 1'b0;

   // Colour bar table, white .. black.
   logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

   initial clk_low = 1'b0;
   always #5 clk_low = ~clk_low;

   always @(posedge clk_low) run_d <= enable;

   function automatic out_t idle_rec();
      out_t e;
      e    = '0;
      e.hs = 1'b1;
      e.vs = 1'b1;
      e.fc = 16'(idle_fc);
      return e;
   endfunction

   // Expected pins for counter state (h,v); fcp is the frame's count, fco the shown count.
   function automatic out_t exp_rec(int h, int v, logic [2:0] m, int fcp, int fco);
      out_t e;
      logic act;
      logic [7:0] g;
      act  = (h < 16) && (v < 4);
      e    = '0;
      e.hs = !(h >= 18 && h <= 20);
      e.vs = (v != 5);
      e.de = act;
      e.fs = (h == 0) && (v == 0);
      e.fc = 16'(fco);
      if (act) begin
         e.x = 16'(h);
         e.y = 16'(v);
         case (m)
            3'd0: {e.r, e.g, e.b} = {solid_r, solid_g, solid_b};
            3'd1: {e.r, e.g, e.b} = bars[h / 2];
            3'd2: begin g = 8'(h); {e.r, e.g, e.b} = {g, g, g}; end
            3'd3: begin
               g = ((((h >> 1) ^ (v >> 1)) & 1) != 0) ? 8'h00 : 8'hFF;
               {e.r, e.g, e.b} = {g, g, g};
            end
            3'd4: begin g = 8'(h + fcp); {e.r, e.g, e.b} = {g, g, g}; end
            default: {e.r, e.g, e.b} = 24'h0;
         endcase
      end
      return e;
   endfunction

   task automatic check_out(input string name, input out_t exp);
      out_t got;
      got = '{hs: hsync, vs: vsync, de: de, fs: frame_start, x: pix_x, y: pix_y,
              fc: frame_cnt, r: red, g: green, b: blue};
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got hs=%0d vs=%0d de=%0d fs=%0d x=%0d y=%0d fc=%0d rgb=%h/%h/%h, expected hs=%0d vs=%0d de=%0d fs=%0d x=%0d y=%0d fc=%0d rgb=%h/%h/%h",
                  name, got.hs, got.vs, got.de, got.fs, got.x, got.y, got.fc, got.r, got.g, got.b,
                  exp.hs, exp.vs, exp.de, exp.fs, exp.x, exp.y, exp.fc, exp.r, exp.g, exp.b);
      end
   endtask

   // Monitor: running cycles pop the scoreboard, idle cycles must show idle values.
   always @(negedge clk_low) begin
      if (run_d) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_output: got x=%0d y=%0d de=%0d, expected no output", pix_x, pix_y, de);
         end else begin
            check_out("run", q.pop_front());
         end
      end else begin
         check_out("idle", idle_rec());
      end
   end

   // Monitor for checks taken between clock edges.
   always @(async_ev) begin
      if (q_async.size() != 0) check_out("async_reset", q_async.pop_front());
   end

   // Queue nfr frames (frame 0 in m0, later frames in m1) and run them; optionally
   // switch the mode input after sw_at cycles.
   task automatic run(input int nfr, input logic [2:0] m0, input logic [2:0] m1, input int sw_at);
      for (int f = 0; f < nfr; f++)
         for (int v = 0; v < 7; v++)
            for (int h = 0; h < 24; h++)
               q.push_back(exp_rec(h, v, (f == 0) ? m0 : m1, fc_base + f,
                                   (h == 23 && v == 6) ? fc_base + f + 1 : fc_base + f));
      mode = m0;
      @(posedge clk_low); #2;
      enable = 1'b1;
      if (sw_at >= 0) begin
         repeat (sw_at) @(posedge clk_low);
         #2 mode = m1;
         repeat (nfr * 168 - sw_at) @(posedge clk_low);
      end else begin
         repeat (nfr * 168) @(posedge clk_low);
      end
      #2;
      enable  = 1'b0;
      fc_base = fc_base + nfr;
      idle_fc = fc_base;
      @(posedge clk_low); #2;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got no finish, expected finish within 200000 ns");
      $fatal(1, "timeout");
   end

   initial begin
      reset_n = 1'b0;
      enable  = 1'b0;
      mode    = 3'd0;
      solid_r = 8'h11;
      solid_g = 8'h22;
      solid_b = 8'h33;
      repeat (3) @(posedge clk_low);
      #2 reset_n = 1'b1;
      @(posedge clk_low); #2;

      run(1, 3'd0, 3'd0, -1);   // solid 11/22/33, full timing
      run(1, 3'd1, 3'd1, -1);   // colour bars
      run(1, 3'd3, 3'd3, -1);   // checkerboard, 2-pixel squares
      run(2, 3'd0, 3'd2, 29);   // mode 0 -> 2 at pixel (5,1), effective next frame
      run(3, 3'd4, 3'd4, -1);   // scrolling gradient

      // Reset pulsed mid-line while running, then re-enabled.
      mode = 3'd0;
      @(posedge clk_low); #2;
      for (int i = 0; i < 29; i++)
         q.push_back(exp_rec(i % 24, i / 24, 3'd0, fc_base, fc_base));
      enable = 1'b1;
      repeat (29) @(posedge clk_low);
      #7;
      reset_n = 1'b0;
      enable  = 1'b0;
      fc_base = 0;
      idle_fc = 0;
      #1;
      q_async.push_back(idle_rec());
      -> async_ev;
      @(posedge clk_low); #2;
      repeat (2) @(posedge clk_low);
      #2 reset_n = 1'b1;
      @(posedge clk_low); #2;
      run(1, 3'd0, 3'd0, -1);

      repeat (3) @(posedge clk_low);
      #2;
      checks++;
      if (q.size() != 0 || q_async.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d records left, expected 0", q.size() + q_async.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
